// File: rtl/wb_slave_regs.sv
// Wishbone classic-cycle slave with a small bank of read/write registers and programmable wait
// states. Define WB_SLAVE_INTR_EN to turn the top register into an interrupt doorbell.
module wb_slave_regs #(
  parameter int unsigned    AW          = 8,
  parameter int unsigned    DW          = 8,
  parameter int unsigned    SW          = 1,
  parameter logic [AW-1:0]  BASE_ADDR   = 'hF0,
  parameter int unsigned    NREGS       = 16,
  parameter int unsigned    WAIT_STATES = 1
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [AW-1:0] ADR_I,
  input  logic [DW-1:0] DAT_I,
  output logic [DW-1:0] DAT_O,
  input  logic          WE_I,
  input  logic [SW-1:0] SEL_I,
  input  logic          STB_I,
  input  logic          CYC_I,
  output logic          ACK_O,
  output logic          ERR_O,
  output logic          INTR_O
);

  localparam int unsigned OW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int unsigned LW = DW / SW;
  localparam int unsigned CW = 4;
  localparam logic [AW:0] NregsExt = (AW + 1)'(NREGS);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWait    = 3'd1,
    StAck     = 3'd2,
    StErr     = 3'd3,
    StRelease = 3'd4
  } state_e;

  state_e          r_state, w_state_d;
  logic [CW-1:0]   r_cnt, w_cnt_d;
  logic [OW-1:0]   r_off;
  logic            r_we;
  logic [DW-1:0]   r_dat;
  logic [SW-1:0]   r_sel;
  logic [DW-1:0]   r_regs [NREGS];

  logic            w_req;
  logic [AW:0]     w_diff;
  logic            w_hit;
  logic [OW-1:0]   w_off;

  assign w_req  = CYC_I & STB_I;
  // One extra bit so addresses below BASE_ADDR show up as a negative difference.
  assign w_diff = {1'b0, ADR_I} - {1'b0, BASE_ADDR};
  assign w_hit  = ~w_diff[AW] && (w_diff < NregsExt);
  assign w_off  = w_diff[OW-1:0];

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_req) begin
          if (!w_hit || (SEL_I == '0)) begin
            w_state_d = StErr;
          end else if (WAIT_STATES == 0) begin
            w_state_d = StAck;
          end else begin
            w_state_d = StWait;
            w_cnt_d   = CW'(WAIT_STATES - 1);
          end
        end
      end
      StWait: begin
        if (!w_req) begin
          w_state_d = StIdle;
        end else if (r_cnt == '0) begin
          w_state_d = StAck;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      StAck:     w_state_d = StRelease;
      StErr:     w_state_d = StRelease;
      StRelease: if (!STB_I) w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Request fields are captured once in IDLE and held for the whole transfer.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_off <= '0;
      r_we  <= 1'b0;
      r_dat <= '0;
      r_sel <= '0;
    end else if ((r_state == StIdle) && w_req) begin
      r_off <= w_off;
      r_we  <= WE_I;
      r_dat <= DAT_I;
      r_sel <= SEL_I;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        r_regs[i] <= '0;
      end
    end else if ((r_state == StAck) && r_we) begin
      for (int l = 0; l < int'(SW); l++) begin
        if (r_sel[l]) begin
          r_regs[r_off][l*LW +: LW] <= r_dat[l*LW +: LW];
        end
      end
    end
  end

  always_comb begin
    DAT_O = '0;
    if ((r_state == StAck) && !r_we) begin
      DAT_O = r_regs[r_off];
    end
  end

  assign ACK_O = (r_state == StAck);
  assign ERR_O = (r_state == StErr);

`ifdef WB_SLAVE_INTR_EN
  localparam logic [OW-1:0] DoorbellOff = OW'(NREGS - 1);

  logic r_intr;

  // A completed write to the doorbell rings it; a completed read acknowledges it.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_intr <= 1'b0;
    end else if ((r_state == StAck) && (r_off == DoorbellOff)) begin
      r_intr <= r_we;
    end
  end

  assign INTR_O = r_intr;
`else
  assign INTR_O = 1'b0;
`endif

endmodule

// File: tb/tb_wb_slave_regs.sv
// Scoreboard bench for wb_slave_regs: two instances (1 and 3 wait states) driven with directed
// and randomized Wishbone transfers, checked against a simple register-file model.
module tb_wb_slave_regs;

  localparam int WS0 = 1;
  localparam int WS1 = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] adr   [2];
  logic [7:0] dat_w [2];
  logic [7:0] dat_r [2];
  logic       we    [2];
  logic [0:0] sel   [2];
  logic       stb   [2];
  logic       cyc   [2];
  logic       ack   [2];
  logic       err   [2];
  logic       intr  [2];

  always #5 clk = ~clk;

  wb_slave_regs #(.WAIT_STATES(WS0)) u_dut0 (
    .CLK_I(clk), .RST_I(rst_n), .ADR_I(adr[0]), .DAT_I(dat_w[0]), .DAT_O(dat_r[0]),
    .WE_I(we[0]), .SEL_I(sel[0]), .STB_I(stb[0]), .CYC_I(cyc[0]), .ACK_O(ack[0]),
    .ERR_O(err[0]), .INTR_O(intr[0])
  );

  wb_slave_regs #(.WAIT_STATES(WS1)) u_dut1 (
    .CLK_I(clk), .RST_I(rst_n), .ADR_I(adr[1]), .DAT_I(dat_w[1]), .DAT_O(dat_r[1]),
    .WE_I(we[1]), .SEL_I(sel[1]), .STB_I(stb[1]), .CYC_I(cyc[1]), .ACK_O(ack[1]),
    .ERR_O(err[1]), .INTR_O(intr[1])
  );

  typedef struct {
    bit         is_err;
    bit         is_wr;
    logic [7:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model: plain storage per instance plus the doorbell flag.
  logic [7:0] mem [2][16];
  bit         intr_m [2];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int q_size(input int b);
    return (b == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void sb_push(input int b, input exp_t e);
    if (b == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  function automatic exp_t sb_pop(input int b);
    return (b == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  function automatic void sb_drop_last(input int b);
    if (b == 0) void'(q0.pop_back());
    else void'(q1.pop_back());
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      intr_m[b] = 1'b0;
      for (int i = 0; i < 16; i++) mem[b][i] = 8'h00;
    end
  endtask

  // Monitor: every response the DUT presents must match the oldest expected entry.
  always @(negedge clk) begin
    for (int b = 0; b < 2; b++) begin
      check($sformatf("ack_err_excl%0d", b), {31'd0, ack[b] & err[b]}, 32'd0);
      if (!ack[b]) check($sformatf("dat_idle%0d", b), {24'd0, dat_r[b]}, 32'd0);
      if (ack[b] || err[b]) begin
        if (q_size(b) == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp%0d: got ack=%b err=%b expected no response (t=%0t)",
                   b, ack[b], err[b], $time);
        end else begin
          exp_t e;
          e = sb_pop(b);
          check($sformatf("resp_kind%0d", b), {30'd0, ack[b], err[b]},
                e.is_err ? 32'd1 : 32'd2);
          if (ack[b] && !e.is_wr) check($sformatf("read_data%0d", b), {24'd0, dat_r[b]},
                                        {24'd0, e.data});
        end
      end
    end
  end

  task automatic xfer(input int b, input logic [7:0] a, input bit w, input logic [7:0] d,
                      input logic [0:0] s, input int hold, input bit abort_it);
    exp_t       e;
    bit         is_err;
    bit         seen;
    int         lat;
    int         ws;
    logic [3:0] o;
    ws     = (b == 0) ? WS0 : WS1;
    is_err = !((int'(a) >= 'hF0) && (int'(a) <= 'hF0 + 15)) || (s == 1'b0);
    o      = 4'(a - 8'hF0);
    @(posedge clk);
    #1;
    adr[b] = a; we[b] = w; dat_w[b] = d; sel[b] = s; cyc[b] = 1'b1; stb[b] = 1'b1;
    if (abort_it) begin
      @(posedge clk);
      #1 adr[b] = ~a; dat_w[b] = ~d;
      @(posedge clk);
      #1 cyc[b] = 1'b0; stb[b] = 1'b0;
      repeat (6) @(posedge clk);
      return;
    end
    e.is_err = is_err;
    e.is_wr  = w;
    e.data   = w ? d : mem[b][o];
    sb_push(b, e);
    seen = 1'b0;
    lat  = 0;
    @(posedge clk);
    // Bus changes after the sampling edge must be ignored.
    #1 adr[b] = 8'($urandom); dat_w[b] = 8'($urandom);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack[b] || err[b]) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
      @(posedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout%0d: got no response expected ack/err within 20 cycles", b);
      sb_drop_last(b);
    end else begin
      check($sformatf("latency%0d", b), lat, is_err ? 0 : ws);
    end
    if (!is_err) begin
      if (w) mem[b][o] = d;
`ifdef WB_SLAVE_INTR_EN
      if (o == 4'hF) intr_m[b] = w;
`endif
    end
    @(posedge clk);
    #1 check($sformatf("intr%0d", b), {31'd0, intr[b]}, {31'd0, intr_m[b]});
    // Held strobe presents a different write; a second access must not happen.
    for (int h = 0; h < hold; h++) begin
      we[b] = 1'b1; adr[b] = 8'hF0 | 8'($urandom_range(0, 15));
      dat_w[b] = 8'($urandom); sel[b] = 1'b1;
      @(posedge clk);
      #1;
    end
    cyc[b] = 1'b0; stb[b] = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected end of test before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int b = 0; b < 2; b++) begin
      adr[b] = '0; dat_w[b] = '0; we[b] = 1'b0; sel[b] = 1'b0; stb[b] = 1'b0; cyc[b] = 1'b0;
    end
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    for (int b = 0; b < 2; b++) begin
      check($sformatf("rst_out%0d", b), {21'd0, ack[b], err[b], intr[b], dat_r[b]}, 32'd0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Basic write/read and error cases.
    xfer(0, 8'hF3, 1'b1, 8'hA5, 1'b1, 0, 1'b0);
    xfer(0, 8'hF3, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    xfer(0, 8'h10, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    xfer(0, 8'hF3, 1'b1, 8'h3C, 1'b0, 0, 1'b0);
    xfer(0, 8'hF3, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    xfer(0, 8'hEF, 1'b1, 8'h11, 1'b1, 0, 1'b0);

    // Held strobe for three cycles past ACK.
    xfer(0, 8'hF7, 1'b1, 8'h96, 1'b1, 3, 1'b0);
    xfer(0, 8'hF7, 1'b0, 8'h00, 1'b1, 3, 1'b0);

    // Abort in the second wait cycle.
    xfer(1, 8'hF4, 1'b1, 8'h21, 1'b1, 0, 1'b0);
    xfer(1, 8'hF4, 1'b1, 8'h5A, 1'b1, 0, 1'b1);
    xfer(1, 8'hF4, 1'b0, 8'h00, 1'b1, 0, 1'b0);

    // Doorbell: set, survive an errored access, clear on read.
    xfer(0, 8'hFF, 1'b1, 8'h01, 1'b1, 0, 1'b0);
    xfer(0, 8'hFF, 1'b1, 8'h07, 1'b0, 0, 1'b0);
    xfer(0, 8'h20, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    xfer(0, 8'hFF, 1'b0, 8'h00, 1'b1, 0, 1'b0);

    // Randomized traffic on both instances.
    for (int n = 0; n < 160; n++) begin
      int         b;
      logic [7:0] a;
      logic [0:0] s;
      bit         w;
      bit         ab;
      b  = int'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 'hEF))
                                       : 8'('hF0 + $urandom_range(0, 15));
      s  = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
      w  = 1'($urandom_range(0, 1));
      ab = (b == 1) && (a >= 8'hF0) && (s == 1'b1) && ($urandom_range(0, 9) == 0);
      xfer(b, a, w, 8'($urandom), s, int'($urandom_range(0, 3)), ab);
    end

    // Reset during bus0 ACK (read of non-zero data) while bus1 is mid-wait on a write.
    xfer(0, 8'hF5, 1'b1, 8'h77, 1'b1, 0, 1'b0);
    @(posedge clk);
    #1;
    adr[0] = 8'hF5; we[0] = 1'b0; sel[0] = 1'b1; cyc[0] = 1'b1; stb[0] = 1'b1;
    adr[1] = 8'hF6; we[1] = 1'b1; dat_w[1] = 8'h33; sel[1] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
    begin
      exp_t e;
      e.is_err = 1'b0; e.is_wr = 1'b0; e.data = mem[0][5];
      sb_push(0, e);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int b = 0; b < 2; b++) begin
      check($sformatf("rst_async%0d", b), {21'd0, ack[b], err[b], intr[b], dat_r[b]}, 32'd0);
    end
    for (int b = 0; b < 2; b++) begin
      cyc[b] = 1'b0; stb[b] = 1'b0;
    end
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      xfer(0, 8'(8'hF0 + i), 1'b0, 8'h00, 1'b1, 0, 1'b0);
      xfer(1, 8'(8'hF0 + i), 1'b0, 8'h00, 1'b1, 0, 1'b0);
    end

    repeat (4) @(posedge clk);
    check("sb_empty0", q0.size(), 0);
    check("sb_empty1", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_slave_regs.md
Name: wb_slave_regs

Overview:
- Wishbone classic-cycle slave: the responder end of the team's Wishbone master interface.
- Holds a small bank of 8-bit read/write registers mapped at BASE_ADDR; the default window 0xF0–0xFF covers the master's 0xFF data address.
- Generates ACK_O after a programmable number of wait states and ERR_O on illegal accesses.
- Optionally raises INTR_O via a doorbell register.

Parameters:
- AW, 8, address bus width.
- DW, 8, data bus width.
- SW, 1, select bus width.
- BASE_ADDR, 8'hF0, first address of the register window.
- NREGS, 16, number of registers; power of two, ≤ 2^AW.
- WAIT_STATES, 1, cycles inserted between request acceptance and ACK_O; 0–15.

Ports:
- CLK_I  in  1  system clock; all state updates on the rising edge.
- RST_I  in  1  asynchronous, active-low reset (0 = reset).
- ADR_I  in  AW  address.
- DAT_I  in  DW  write data.
- DAT_O  out  DW  read data.
- WE_I  in  1  1 = write, 0 = read.
- SEL_I  in  SW  byte select.
- STB_I  in  1  strobe.
- CYC_I  in  1  bus cycle valid.
- ACK_O  out  1  normal termination.
- ERR_O  out  1  error termination.
- INTR_O  out  1  interrupt request; optional feature, tied 0 when disabled.

Behaviour:
- Reset (RST_I=0, asynchronous): state=IDLE, all registers=0, wait counter=0, DAT_O=0, ACK_O=0, ERR_O=0, INTR_O=0.
  - Reset asserted mid-transfer aborts the transfer: no write, no ACK.
- Outputs are never driven to Z.
- State machine (3-bit): IDLE, WAIT, ACK, ERR, RELEASE.
- IDLE:
  - On a rising edge with CYC_I=1 and STB_I=1, latch ADR_I, WE_I, DAT_I and SEL_I.
  - Hit: BASE_ADDR ≤ ADR_I ≤ BASE_ADDR+NREGS-1. Register offset = ADR_I - BASE_ADDR, truncated to log2(NREGS) bits.
  - Miss, or SEL_I==0 -> ERR.
  - Hit with WAIT_STATES==0 -> ACK.
  - Hit otherwise -> WAIT, counter loaded with WAIT_STATES-1.
- WAIT:
  - Counter decrements each cycle; counter==0 -> ACK.
  - CYC_I=0 or STB_I=0 during WAIT -> IDLE (abort): no write, no ACK_O, no ERR_O.
- ACK:
  - ACK_O=1 for exactly one cycle.
  - Read: DAT_O = reg[offset] for that cycle; DAT_O=0 in every other state.
  - Write: reg[offset] <= latched data on the edge ending the ACK cycle.
  - Next state: RELEASE.
- ERR: ERR_O=1 for exactly one cycle; no register or INTR_O change; next state RELEASE.
- RELEASE:
  - Stay while STB_I=1; -> IDLE when STB_I=0.
  - Guarantees one access per strobe when the master holds STB_I a cycle past ACK.
- ACK_O and ERR_O are decoded from registered state only (Moore). They are never both 1.
- Latency: request sampled at edge E0 -> ACK_O (or ERR_O) high between edges E0+WAIT_STATES and E0+WAIT_STATES+1.
  - ERR always takes 1 cycle, regardless of WAIT_STATES.
- The latched address is used throughout the transfer; ADR_I/DAT_I changes after E0 are ignored.

Optional Feature:
- Macro: WB_SLAVE_INTR_EN.
- Defined:
  - Offset NREGS-1 is the doorbell register.
  - A completed write to it stores the data and sets INTR_O=1 on the edge ending ACK.
  - A completed read of it returns the stored value and clears INTR_O on the same edge.
  - Aborted or errored accesses do not affect INTR_O.
  - INTR_O stays 1 until read or reset.
- Not defined: INTR_O tied 0; offset NREGS-1 is an ordinary storage register.

Test Plan:
- Reset: RST_I=0 mid-WAIT with CYC_I/STB_I=1 -> outputs 0 immediately (no clock needed); after release, reads of 0xF0..0xFF return 0x00.
- Write/read, default WAIT_STATES=1:
  - Write 0xA5 to 0xF3 -> ACK_O high in 2nd cycle after sampling, exactly 1 cycle wide.
  - Read 0xF3 -> DAT_O=0xA5 during ACK, 0x00 otherwise.
- Error: read 0x10, or write 0xF3 with SEL_I=0 -> ERR_O 1 cycle, ACK_O stays 0, reg 0xF3 still 0xA5.
- Held strobe: master keeps CYC_I/STB_I=1 for 3 cycles after ACK -> exactly one ACK and one write; next access accepted only after STB_I drops.
- Abort: WAIT_STATES=3, write 0x5A to 0xF4, drop CYC_I in 2nd WAIT cycle -> no ACK_O, reg 0xF4 unchanged, state returns to IDLE.
- WB_SLAVE_INTR_EN defined:
  - Write 0x01 to 0xFF -> INTR_O=1 after ACK.
  - Read 0xFF -> returns 0x01, INTR_O=0 after ACK.
  - Errored access leaves INTR_O unchanged.
